// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a registered high pulse of programmable length,
// then holds the output low for a minimum gap. Rejected triggers are flagged and counted.
module pulse_stretcher #(
   parameter int CNT_W   = 8,
   parameter int GAP_CYC = 2,
   parameter int RETRIG  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [CNT_W-1:0] len,
   output logic             out,
   output logic             busy,
   output logic             missed,
   output logic [7:0]       miss_cnt
);

   localparam int GAP_LD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] w_hcnt_nxt;
   logic [CNT_W-1:0] r_gcnt;
   logic [CNT_W-1:0] w_gcnt_nxt;
   logic             r_out;
   logic             r_busy;
   logic             r_missed;
   logic [7:0]       r_miss_cnt;
   logic             w_len_ok;
   logic             w_reload;
   logic             w_miss;

   assign w_len_ok = (len != '0);
   assign w_reload = trig && (RETRIG != 0) && w_len_ok;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      w_gcnt_nxt  = r_gcnt;
      w_miss      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A zero-length request is simply ignored, not counted as missed.
            if (trig && w_len_ok) begin
               w_state_nxt = S_HIGH;
               w_hcnt_nxt  = len - CNT_W'(1);
            end
         end
         S_HIGH: begin
            w_miss = trig && (RETRIG == 0);
            if (w_reload) begin
               w_hcnt_nxt = len - CNT_W'(1);
            end else if (r_hcnt == '0) begin
               if (GAP_CYC == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_GAP;
                  w_gcnt_nxt  = CNT_W'(GAP_LD);
               end
            end else begin
               w_hcnt_nxt = r_hcnt - CNT_W'(1);
            end
         end
         S_GAP: begin
            w_miss = trig;
            if (r_gcnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gcnt_nxt = r_gcnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_hcnt     <= '0;
         r_gcnt     <= '0;
         r_out      <= 1'b0;
         r_busy     <= 1'b0;
         r_missed   <= 1'b0;
         r_miss_cnt <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_hcnt   <= w_hcnt_nxt;
         r_gcnt   <= w_gcnt_nxt;
         r_out    <= (w_state_nxt == S_HIGH);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_missed <= w_miss;
         if (w_miss && (r_miss_cnt != 8'hFF)) begin
            r_miss_cnt <= r_miss_cnt + 8'd1;
         end
      end
   end

   assign out      = r_out;
   assign busy     = r_busy;
   assign missed   = r_missed;
   assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Drives three pulse_stretcher variants (no retrigger, retrigger, zero gap) with shared
// stimulus and compares them against a time-window reference model.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trig;
   logic [7:0] len;
   logic [2:0] dut_out;
   logic [2:0] dut_busy;
   logic [2:0] dut_missed;
   logic [7:0] dut_cnt [3];

   int n_cmp = 0;
   int n_err = 0;

   // Variant parameters, indexed like the instances below.
   int gap_p [3] = '{2, 2, 0};
   int rtg_p [3] = '{0, 1, 0};

   always #5 clk = ~clk;

   pulse_stretcher #(.CNT_W(8), .GAP_CYC(2), .RETRIG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len),
      .out(dut_out[0]), .busy(dut_busy[0]), .missed(dut_missed[0]), .miss_cnt(dut_cnt[0])
   );
   pulse_stretcher #(.CNT_W(8), .GAP_CYC(2), .RETRIG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len),
      .out(dut_out[1]), .busy(dut_busy[1]), .missed(dut_missed[1]), .miss_cnt(dut_cnt[1])
   );
   pulse_stretcher #(.CNT_W(8), .GAP_CYC(0), .RETRIG(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len),
      .out(dut_out[2]), .busy(dut_busy[2]), .missed(dut_missed[2]), .miss_cnt(dut_cnt[2])
   );

   // Reference model: each pulse is a window of edge indices. Output is high after edges
   // [m_start, m_end), busy after edges before m_idle; the gap is [m_end, m_idle).
   int m_n = 0;
   int m_start [3];
   int m_end   [3];
   int m_idle  [3];
   int m_cnt   [3];
   bit m_miss  [3];

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_start[d] = 0;
         m_end[d]   = 0;
         m_idle[d]  = 0;
         m_cnt[d]   = 0;
         m_miss[d]  = 1'b0;
      end
   endtask

   task automatic model_edge(input bit t, input int l);
      int  p;
      bit  hi;
      bit  gp;
      m_n = m_n + 1;
      p   = m_n - 1;
      for (int d = 0; d < 3; d++) begin
         hi        = (p >= m_start[d]) && (p < m_end[d]);
         gp        = !hi && (p < m_idle[d]);
         m_miss[d] = 1'b0;
         if (t) begin
            if (!hi && !gp) begin
               if (l != 0) begin
                  m_start[d] = m_n;
                  m_end[d]   = m_n + l;
                  m_idle[d]  = m_end[d] + gap_p[d];
               end
            end else if (hi && rtg_p[d] == 1) begin
               if (l != 0) begin
                  m_end[d]  = m_n + l;
                  m_idle[d] = m_end[d] + gap_p[d];
               end
            end else begin
               m_miss[d] = 1'b1;
               m_cnt[d]  = (m_cnt[d] < 255) ? m_cnt[d] + 1 : 255;
            end
         end
      end
   endtask

   function automatic logic [10:0] obs(input int d);
      return {dut_out[d], dut_busy[d], dut_missed[d], dut_cnt[d]};
   endfunction

   function automatic logic [10:0] expv(input int d);
      logic e_out;
      logic e_busy;
      e_out  = (m_n >= m_start[d]) && (m_n < m_end[d]);
      e_busy = (m_n < m_idle[d]);
      return {e_out, e_busy, m_miss[d], 8'(m_cnt[d])};
   endfunction

   // One clock: drive inputs at the falling edge, advance the model at the rising edge,
   // and return at the next falling edge where outputs are sampled.
   task automatic step(input bit t, input int l);
      trig = t;
      len  = 8'(l);
      @(posedge clk);
      model_edge(t, l);
      @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      trig  = 1'b0;
      len   = 8'd0;
      model_reset();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs(d) !== 11'h000) begin
            n_err++;
            $display("FAIL reset_hold dut%0d got %h expected %h", d, obs(d), 11'h000);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 0);
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL reset_idle dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
   endtask

   task automatic test_basic();
      int hi_cnt = 0;
      int bz_cnt = 0;
      int ms_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) step(1'b1, 3); else step(1'b0, 0);
         hi_cnt += int'(dut_out[0]);
         bz_cnt += int'(dut_busy[0]);
         ms_cnt += int'(dut_missed[0]);
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL basic dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
      n_cmp++;
      if (hi_cnt !== 3 || bz_cnt !== 5 || ms_cnt !== 0) begin
         n_err++;
         $display("FAIL basic_widths high/busy/missed got %0d/%0d/%0d expected 3/5/0", hi_cnt, bz_cnt, ms_cnt);
      end
   endtask

   task automatic test_retrigger();
      int         hi0 = 0;
      int         hi1 = 0;
      int         falls1 = 0;
      logic       prev1 = 1'b0;
      logic [7:0] c0 = dut_cnt[0];
      logic [7:0] c1 = dut_cnt[1];
      for (int i = 0; i < 12; i++) begin
         if (i == 0 || i == 2) step(1'b1, 4); else step(1'b0, 0);
         hi0 += int'(dut_out[0]);
         hi1 += int'(dut_out[1]);
         if (prev1 && !dut_out[1]) falls1++;
         prev1 = dut_out[1];
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL retrig dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
      n_cmp++;
      if (hi0 !== 4 || dut_cnt[0] !== c0 + 8'd1) begin
         n_err++;
         $display("FAIL retrig_off high/miss_delta got %0d/%0d expected 4/1", hi0, dut_cnt[0] - c0);
      end
      n_cmp++;
      if (hi1 !== 6 || falls1 !== 1 || dut_cnt[1] !== c1) begin
         n_err++;
         $display("FAIL retrig_on high/falls/miss_delta got %0d/%0d/%0d expected 6/1/0",
                  hi1, falls1, dut_cnt[1] - c1);
      end
   endtask

   task automatic test_gap_miss();
      int         hi0 = 0;
      logic [7:0] c0 = dut_cnt[0];
      for (int i = 0; i < 16; i++) begin
         if (i == 0) step(1'b1, 3);
         else if (i == 4) step(1'b1, 3);
         else if (i == 6) step(1'b1, 2);
         else step(1'b0, 0);
         hi0 += int'(dut_out[0]);
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL gap_miss dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
      n_cmp++;
      if (hi0 !== 5 || dut_cnt[0] !== c0 + 8'd1) begin
         n_err++;
         $display("FAIL gap_miss_totals high/miss_delta got %0d/%0d expected 5/1", hi0, dut_cnt[0] - c0);
      end
   endtask

   task automatic test_len_zero();
      logic [7:0] c [3];
      for (int d = 0; d < 3; d++) c[d] = dut_cnt[d];
      for (int i = 0; i < 6; i++) begin
         step(i[0] == 1'b0, 0);
         n_cmp++;
         if ({dut_out, dut_busy, dut_missed} !== 9'd0) begin
            n_err++;
            $display("FAIL len_zero out/busy/missed got %b/%b/%b expected 000/000/000",
                     dut_out, dut_busy, dut_missed);
         end
      end
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (dut_cnt[d] !== c[d]) begin
            n_err++;
            $display("FAIL len_zero_cnt dut%0d got %0d expected %0d", d, dut_cnt[d], c[d]);
         end
      end
   endtask

   task automatic test_gap0_back_to_back();
      int   run    = 0;
      int   pulses = 0;
      logic seen   = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 2);
         if (dut_out[2]) begin
            if (seen && run != 0) begin
               n_cmp++;
               if (run !== 1) begin
                  n_err++;
                  $display("FAIL gap0_low_run got %0d expected 1", run);
               end
            end
            if (!seen || run != 0) pulses++;
            seen = 1'b1;
            run  = 0;
         end else if (seen) begin
            run++;
         end
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL gap0 dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
      n_cmp++;
      if (pulses < 3) begin
         n_err++;
         $display("FAIL gap0_pulses got %0d expected at least 3", pulses);
      end
   endtask

   task automatic test_random();
      bit t;
      int l;
      for (int i = 0; i < 600; i++) begin
         t = ($urandom_range(0, 9) < 4);
         case ($urandom_range(0, 7))
            0:       l = 0;
            1:       l = $urandom_range(8, 20);
            default: l = $urandom_range(1, 6);
         endcase
         step(t, l);
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL random dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      idle(25);
      step(1'b1, 10);
      step(1'b0, 0);
      step(1'b0, 0);
      n_cmp++;
      if (dut_out !== 3'b111) begin
         n_err++;
         $display("FAIL async_pre out got %b expected 111", dut_out);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs(d) !== 11'h000) begin
            n_err++;
            $display("FAIL async_reset dut%0d got %h expected %h", d, obs(d), 11'h000);
         end
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 0);
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL async_after dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
   endtask

   task automatic test_saturation();
      int first_low = -1;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 255);
         if (!dut_out[0] && first_low < 0) first_low = i;
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== expv(d)) begin
               n_err++;
               $display("FAIL saturate dut%0d edge=%0d got %h expected %h", d, m_n, obs(d), expv(d));
            end
         end
      end
      n_cmp++;
      if (first_low !== 255) begin
         n_err++;
         $display("FAIL max_len high cycles got %0d expected 255", first_low);
      end
      n_cmp++;
      if (dut_cnt[0] !== 8'd255 || dut_cnt[1] !== 8'd0 || dut_cnt[2] !== 8'd255) begin
         n_err++;
         $display("FAIL saturate_cnt got %0d/%0d/%0d expected 255/0/255", dut_cnt[0], dut_cnt[1], dut_cnt[2]);
      end
   endtask

   initial begin
      test_reset();
      idle(4);
      test_basic();
      idle(4);
      test_retrigger();
      idle(4);
      test_gap_miss();
      idle(4);
      test_len_zero();
      idle(4);
      test_gap0_back_to_back();
      idle(12);
      test_random();
      test_async_reset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
